// File: rtl/mult_iterative_unit.sv
// Iterative shift-add multiplier (MULT/MULTU) producing a 2*LENGTH-bit product in hi/lo.
// Optional macro MULT_ZERO_BYPASS_EN: a zero operand skips the iteration and finishes in one cycle.
module mult_iterative_unit #(
  parameter int LENGTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic              is_signed,
  input  logic [LENGTH-1:0] A,
  input  logic [LENGTH-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [LENGTH-1:0] hi,
  output logic [LENGTH-1:0] lo
);

  localparam int CW = $clog2(LENGTH + 1);

  // Handshake: start is taken only in IDLE on an enabled edge; busy is high
  // whenever the unit is not IDLE; done is high for the single DONE cycle, and
  // hi/lo are valid from that cycle until the next DONE or reset. enable=0
  // freezes every register, so done stays high while stalled in DONE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*LENGTH-1:0] acc_q, acc_d;
  logic [LENGTH-1:0]   mcand_q, mcand_d;
  logic [LENGTH-1:0]   mplier_q, mplier_d;
  logic                sign_q, sign_d;
  logic [LENGTH-1:0]   hi_q, hi_d;
  logic [LENGTH-1:0]   lo_q, lo_d;

  logic [LENGTH-1:0]   a_abs;
  logic [LENGTH-1:0]   b_abs;
  logic [LENGTH:0]     sum;
  logic [2*LENGTH-1:0] product;

  // Negating the most negative value yields the same bit pattern, which is
  // exactly its magnitude when read as unsigned.
  assign a_abs   = (is_signed && A[LENGTH-1]) ? -A : A;
  assign b_abs   = (is_signed && B[LENGTH-1]) ? -B : B;
  assign sum     = {1'b0, acc_q[2*LENGTH-1:LENGTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign product = sign_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sign_d   = is_signed & (A[LENGTH-1] ^ B[LENGTH-1]);
            mcand_d  = a_abs;
            mplier_d = b_abs;
            acc_d    = '0;
            cnt_d    = CW'(LENGTH);
            state_d  = S_RUN;
`ifdef MULT_ZERO_BYPASS_EN
            if (A == '0 || B == '0) begin
              hi_d    = '0;
              lo_d    = '0;
              state_d = S_DONE;
            end
`endif
          end
        end
        S_RUN: begin
          // Carry from the upper-half add shifts into the top bit.
          acc_d    = {sum, acc_q[LENGTH-1:1]};
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          hi_d    = product[2*LENGTH-1:LENGTH];
          lo_d    = product[LENGTH-1:0];
          state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_iterative_unit.sv
// Directed bench for mult_iterative_unit: latency, signed/unsigned products, stalls, reset abort.
// Cycle numbering: the cycle right after the start-sampling edge is cycle 1.
module tb_mult_iterative_unit;

  localparam int L = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         start;
  logic         is_signed;
  logic [L-1:0] a;
  logic [L-1:0] b;
  logic         busy;
  logic         done;
  logic [L-1:0] hi;
  logic [L-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int done_seen;
  logic [2*L-1:0] exp_q[$];
  logic [2*L-1:0] exp_v;

  mult_iterative_unit #(.LENGTH(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .start     (start),
    .is_signed (is_signed),
    .A         (a),
    .B         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // driver: wait for IDLE, present operands for one edge, then scramble them
  task automatic do_start(input logic sgn, input logic [L-1:0] av, input logic [L-1:0] bv);
    int guard;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    is_signed = sgn;
    a         = av;
    b         = bv;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    a         = $urandom;
    b         = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    cyc       = 1;
  endtask

  // driver: advance until done, optionally stalling and pulsing start while busy
  task automatic wait_done(input int stall_at, input int stall_len, input int pulse_at, input int budget);
    while (done !== 1'b1 && cyc < budget) begin
      enable = !(cyc >= stall_at && cyc < stall_at + stall_len);
      start  = (cyc == pulse_at);
      @(posedge clk); #1;
      cyc++;
    end
    enable = 1'b1;
    start  = 1'b0;
  endtask

  // scoreboard: compare latency and the oldest expected product
  task automatic check_result(input string tag, input int exp_lat);
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_done"}, 64'(done), 64'(1));
    exp_v = exp_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, exp_v);
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    cyc       = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hilo", {hi, lo}, 64'h0);
    rst = 1'b0;

    // MULTU 3*5, then confirm single-cycle done and held result
    exp_q.push_back(64'h00000000_0000000F);
    do_start(1'b0, 32'd3, 32'd5);
    check("run_busy", 64'(busy), 64'(1));
    wait_done(0, 0, 0, 100);
    check_result("multu_3x5", 34);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    check("hold_hilo", {hi, lo}, 64'h00000000_0000000F);

    // back-to-back start in the cycle after done
    exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
    do_start(1'b1, 32'hFFFFFFFD, 32'd5);
    wait_done(0, 0, 0, 100);
    check_result("mult_m3x5", 34);

    // start issued from the DONE cycle: driver waits out DONE
    exp_q.push_back(64'hFFFFFFFE_00000001);
    do_start(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, 0, 0, 100);
    check_result("multu_ff", 34);

    exp_q.push_back(64'h00000000_00000001);
    do_start(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, 0, 0, 100);
    check_result("mult_m1xm1", 34);

    exp_q.push_back(64'h40000000_00000000);
    do_start(1'b1, 32'h80000000, 32'h80000000);
    wait_done(0, 0, 0, 100);
    check_result("mult_min_sq", 34);

    exp_q.push_back(64'hFFFFFFFF_80000000);
    do_start(1'b1, 32'h80000000, 32'd1);
    wait_done(0, 0, 0, 100);
    check_result("mult_min_x1", 34);

    // 5-cycle stall from cycle 10, plus an ignored start pulse while busy
    exp_q.push_back(64'h00000000_0000003F);
    do_start(1'b0, 32'd7, 32'd9);
    wait_done(10, 5, 5, 100);
    check_result("stall_7x9", 39);

    // freeze in DONE keeps done high
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("frz_done", 64'(done), 64'(1));
    check("frz_busy", 64'(busy), 64'(1));
    check("frz_hilo", {hi, lo}, 64'h00000000_0000003F);
    enable = 1'b1;
    @(posedge clk); #1;
    check("unfrz_done", 64'(done), 64'(0));

    // zero operand
    exp_q.push_back(64'h0);
    do_start(1'b0, 32'd0, 32'h55);
`ifdef MULT_ZERO_BYPASS_EN
    wait_done(0, 0, 0, 100);
    check_result("zero_op", 1);
`else
    wait_done(0, 0, 0, 100);
    check_result("zero_op", 34);
`endif
    check("zero_busy", 64'(busy), 64'(1));

    // load a nonzero result, then abort a multiply with reset at cycle 12
    exp_q.push_back(64'h00000000_00000023);
    do_start(1'b0, 32'd5, 32'd7);
    wait_done(0, 0, 0, 100);
    check_result("multu_5x7", 34);
    do_start(1'b0, 32'h1234, 32'h10);
    while (cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hilo", {hi, lo}, 64'h0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
